// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter -- parameterised free-running binary up-counter with carry-out.
//
// The counter advances by one, modulo 2^WIDTH, on every rising clock edge where
// enb is high. Otherwise it holds its value. carryout flags the cycle in which
// the next enabled edge wraps the counter to zero. Wider counters are built by
// cascading stages: drive stage N+1 enb from stage N carryout.
//
// Parameters:
//   WIDTH     counter width in bits, 1..32 (default 8)
//
// Ports:
//   clk       input            rising-edge clock
//   rst_n     input            asynchronous active-low reset, clears count
//   enb       input            count enable, sampled at rising edges
//   count     output [WIDTH]   current counter value (registered)
//   carryout  output           enb AND (count == 2^WIDTH-1), combinational
//
// Optional build macro:
//   COUNTER_ASSERT_EN  compiles in simulation-only concurrent assertions and
//                      an elaboration-time WIDTH range check. Ports and
//                      behaviour are identical with or without it.
// -----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    output logic [WIDTH-1:0] count,
    output logic             carryout
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // The adder is WIDTH bits wide, so its carry is dropped and wrap-around
    // falls out naturally. The flag comes from a compare, not from the adder.
    always_comb begin
        count_next = count_reg;
        if (enb) begin
            count_next = count_reg + ONE;
        end
    end

    // The register is written on every edge. The hold case simply reloads the
    // current value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count    = count_reg;
    assign carryout = enb & (count_reg == MAX_VAL);

`ifdef COUNTER_ASSERT_EN
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
            $error("counter: WIDTH=%0d outside legal range 1..32", WIDTH);
        end
    endgenerate

    // Enabled edge: the counter must step by exactly one, modulo 2^WIDTH.
    a_step: assert property (@(posedge clk) disable iff (!rst_n)
        enb |=> (count == WIDTH'($past(count) + ONE)));

    // Disabled edge: the counter must hold its value.
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !enb |=> (count == $past(count)));

    // The carry flag must never be raised while counting is disabled.
    a_no_carry_idle: assert property (@(posedge clk)
        !enb |-> !carryout);

    // The carry flag must be high exactly when enabled at the maximum value.
    a_carry_exact: assert property (@(posedge clk)
        carryout == (enb && (count == MAX_VAL)));

    // The counter must read zero for as long as reset is held.
    a_reset_zero: assert property (@(posedge clk)
        !rst_n |-> (count == '0));

    // The enable input must be a known value whenever reset is released.
    a_enb_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(enb));
`endif

endmodule

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter -- self-checking bench for counter.
//
// Instances:
//   u4            WIDTH=4, main device for the vector table and random run
//   u1            WIDTH=1
//   u32           WIDTH=32, preloaded near its maximum value
//   uc0 / uc1     two WIDTH=4 stages cascaded through carryout
//
// Expected values come from a vector table and from integer-arithmetic models
// (count of enabled edges modulo 2^WIDTH).
// -----------------------------------------------------------------------------
module tb_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enb = 1'b0;
    logic        enb1 = 1'b0;
    logic        enb32 = 1'b0;
    logic        casc_en = 1'b0;

    logic [3:0]  count4;
    logic        carry4;
    logic [0:0]  count1;
    logic        carry1;
    logic [31:0] count32;
    logic        carry32;
    logic [3:0]  c0_count;
    logic        c0_carry;
    logic [3:0]  c1_count;
    logic        c1_carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .enb(enb), .count(count4), .carryout(carry4)
    );

    counter #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enb(enb1), .count(count1), .carryout(carry1)
    );

    counter #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .enb(enb32), .count(count32), .carryout(carry32)
    );

    counter #(.WIDTH(4)) uc0 (
        .clk(clk), .rst_n(rst_n), .enb(casc_en), .count(c0_count), .carryout(c0_carry)
    );

    counter #(.WIDTH(4)) uc1 (
        .clk(clk), .rst_n(rst_n), .enb(c0_carry), .count(c1_count), .carryout(c1_carry)
    );

    typedef struct {
        logic       rst_n;
        logic       enb;
        logic [3:0] exp_count;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic e, input logic [3:0] c, input logic k);
        vec_t v;
        v.rst_n     = r;
        v.enb       = e;
        v.exp_count = c;
        v.exp_carry = k;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    int m4;
    int m1;

    initial begin
        // ---------------- vector table, WIDTH=4 ----------------
        // Each record is applied at a falling edge and checked 1 time unit
        // later. exp_count reflects the rising edges seen before that point.
        for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b1, 4'd0, 1'b0);
        add_vec(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) add_vec(1'b1, 1'b1, 4'(i), (i == 15));
        add_vec(1'b1, 1'b0, 4'd0, 1'b0);
        add_vec(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) add_vec(1'b1, 1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 10; i++) add_vec(1'b1, 1'b0, 4'd7, 1'b0);
        add_vec(1'b1, 1'b1, 4'd7, 1'b0);
        add_vec(1'b1, 1'b0, 4'd8, 1'b0);
        for (int i = 8; i < 15; i++) add_vec(1'b1, 1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 4'd15, 1'b0);
        add_vec(1'b1, 1'b1, 4'd15, 1'b1);
        add_vec(1'b1, 1'b0, 4'd0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            enb   = vecs[i].enb;
            #1;
            check($sformatf("tab%0d_count", i), 32'(count4), 32'(vecs[i].exp_count));
            check($sformatf("tab%0d_carry", i), 32'(carry4), 32'(vecs[i].exp_carry));
            $display("vec %0d: rst_n=%0b enb=%0b count=%0d carry=%0b", i,
                     vecs[i].rst_n, vecs[i].enb, count4, carry4);
        end

        // ---------------- asynchronous reset mid-cycle at count=9 ----------------
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            enb = 1'b1;
            #1;
            check("pre_rst_count", 32'(count4), 32'(i));
        end
        @(posedge clk);     // this edge takes the counter to 10
        #3;
        rst_n = 1'b0;
        #1;                 // still well before the next rising edge
        check("async_rst_count", 32'(count4), 32'd0);
        check("async_rst_carry", 32'(carry4), 32'd0);
        $display("async reset: count=%0d carry=%0b", count4, carry4);
        @(negedge clk);
        enb   = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_count", 32'(count4), 32'd0);

        // ---------------- cascade of two WIDTH=4 stages ----------------
        @(negedge clk);
        casc_en = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            #1;
            check("casc_value", {24'd0, c1_count, c0_count}, 32'(i % 256));
            check("casc_hi", 32'(c1_count), 32'((i / 16) % 16));
            check("casc_c0_carry", 32'(c0_carry), 32'((i % 16) == 15));
            if (i % 16 == 0)
                $display("cascade cycle %0d: hi=%0d lo=%0d", i, c1_count, c0_count);
            @(negedge clk);
        end
        casc_en = 1'b0;

        // ---------------- WIDTH=1 toggling ----------------
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enb1 = 1'b1;
            #1;
            check("w1_count", 32'(count1), 32'(i % 2));
            check("w1_carry", 32'(carry1), 32'(i % 2));
            $display("w1 step %0d: count=%0d carry=%0b", i, count1, carry1);
        end
        @(negedge clk);
        enb1 = 1'b0;

        // ---------------- WIDTH=32 wrap from 0xFFFFFFFE ----------------
        @(negedge clk);
        enb32 = 1'b0;
        force u32.count_reg = 32'hFFFF_FFFE;
        @(negedge clk);
        release u32.count_reg;
        #1;
        check("w32_preload_idle_carry", 32'(carry32), 32'd0);
        enb32 = 1'b1;
        #1;
        check("w32_edge0_count", count32, 32'hFFFF_FFFE);
        check("w32_edge0_carry", 32'(carry32), 32'd0);
        @(negedge clk);
        #1;
        check("w32_edge1_count", count32, 32'hFFFF_FFFF);
        check("w32_edge1_carry", 32'(carry32), 32'd1);
        @(negedge clk);
        enb32 = 1'b0;
        #1;
        check("w32_wrap_count", count32, 32'd0);
        check("w32_wrap_carry", 32'(carry32), 32'd0);
        $display("w32 wrap: count=%0h carry=%0b", count32, carry32);

        // ---------------- randomized run against integer models ----------------
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m4 = 0;
        m1 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 24) != 0);
            enb   = 1'($urandom_range(0, 1));
            enb1  = 1'($urandom_range(0, 1));
            if (!rst_n) begin
                m4 = 0;
                m1 = 0;
            end
            #1;
            check("rnd_w4_count", 32'(count4), 32'(m4));
            check("rnd_w4_carry", 32'(carry4), 32'(enb && (m4 == 15)));
            check("rnd_w1_count", 32'(count1), 32'(m1));
            check("rnd_w1_carry", 32'(carry1), 32'(enb1 && (m1 == 1)));
            if (i % 50 == 0)
                $display("rnd %0d: rst_n=%0b enb=%0b count4=%0d model=%0d", i, rst_n, enb, count4, m4);
            @(posedge clk);
            if (rst_n && enb)  m4 = (m4 + 1) % 16;
            if (rst_n && enb1) m1 = (m1 + 1) % 2;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
